uengine_job_issuing: RTL and testbench

- Microengine that pushes one mining job into every enabled engine of one chip over the shared 32-bit-frame SPI master.
- Reads JOB_WORDS 32-bit job words from the local job RAM and writes each word as two 16-bit register writes, low half first.
- Then gives each engine a distinct nonce start and writes its control register to start it.
- It is the write-direction counterpart of the nonce-gathering microengine. It sits beside that engine on the same SPI master and RAM arbitration, under the chip sequencer.

---
 rtl/uengine_pkg.sv | 51 +++++
 rtl/spi_frame_builder.sv | 23 ++
 rtl/uengine_job_issuing.sv | 222 ++++++++++++++++++++++
 tb/tb_uengine_job_issuing.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uengine_pkg.sv
// Shared definitions for the SPI-driving microengines: frame layout, register map,
// and the job-issuing state encoding.
package uengine_pkg;

    // 32-bit SPI frame: {rw, chip[2:0], engine[3:0], regaddr[7:0], data[15:0]}
    localparam int unsigned SPI_FRAME_W    = 32;
    localparam int unsigned SPI_RW_BIT     = 31;
    localparam int unsigned SPI_CHIP_LSB   = 28;
    localparam int unsigned SPI_ENGINE_LSB = 24;
    localparam int unsigned SPI_ADDR_LSB   = 16;
    localparam int unsigned SPI_DATA_LSB   = 0;

    localparam logic SPI_RW_WRITE = 1'b0;
    localparam logic SPI_RW_READ  = 1'b1;

    // Engine register map
    localparam logic [7:0]  REG_CTRL     = 8'h00;
    localparam logic [7:0]  REG_BASE     = 8'h01;
    localparam logic [7:0]  REG_NONCE_LO = 8'h20;
    localparam logic [7:0]  REG_NONCE_HI = 8'h21;
    localparam logic [15:0] CTRL_START   = 16'h0001;

    typedef enum logic [4:0] {
        StIdle,
        StInit,
        StSelect,
        StFetch,
        StFetchWait,
        StLoad,
        StSendLo,
        StWaitLo,
        StSendHi,
        StWaitHi,
        StSendNlo,
        StWaitNlo,
        StSendNhi,
        StWaitNhi,
        StSendCtrl,
        StWaitCtrl,
        StDone
    } job_state_e;

    function automatic logic is_send_state(input job_state_e s);
        return s inside {StSendLo, StSendHi, StSendNlo, StSendNhi, StSendCtrl};
    endfunction

    function automatic logic is_wait_state(input job_state_e s);
        return s inside {StWaitLo, StWaitHi, StWaitNlo, StWaitNhi, StWaitCtrl};
    endfunction

endpackage

// File: rtl/spi_frame_builder.sv
// Combinational assembly of one 32-bit SPI register-access frame.
module spi_frame_builder
    import uengine_pkg::*;
(
    input  logic                   rw_i,
    input  logic [2:0]             chip_i,
    input  logic [3:0]             engine_i,
    input  logic [7:0]             addr_i,
    input  logic [15:0]            data_i,
    output logic [SPI_FRAME_W-1:0] frame_o
);

    // Place each field at its shared bit position.
    always_comb begin
        frame_o                         = '0;
        frame_o[SPI_RW_BIT]             = rw_i;
        frame_o[SPI_CHIP_LSB +: 3]      = chip_i;
        frame_o[SPI_ENGINE_LSB +: 4]    = engine_i;
        frame_o[SPI_ADDR_LSB +: 8]      = addr_i;
        frame_o[SPI_DATA_LSB +: 16]     = data_i;
    end

endmodule

// File: rtl/uengine_job_issuing.sv
// Job-issuing microengine: streams one job from the job RAM into every enabled engine
// of a chip, then seeds each engine's nonce and starts it.
module uengine_job_issuing
    import uengine_pkg::*;
#(
    parameter int unsigned JOB_WORDS = 11,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        SysClock,
    input  logic        SysReset_n,
    input  logic        ModuleStart,
    output logic        ModuleDone,
    output logic        ModuleError,
    output logic        Busy,
    input  logic [15:0] EngineMap,
    input  logic [2:0]  ActualChipIndex,
    output logic [31:0] SPI_TX,
    output logic        SPI_START,
    input  logic        SPI_DONE,
    output logic [8:0]  Memory_Address,
    input  logic [31:0] Memory_ReadData,
    input  logic [8:0]  Memory_Address_To_Start_Reading,
    output logic [4:0]  EnginesIssued
);

    localparam int unsigned WordW = (JOB_WORDS > 1) ? $clog2(JOB_WORDS) : 1;
    localparam int unsigned WdW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WordW-1:0] LastWord = WordW'(JOB_WORDS - 1);
    localparam logic [WdW-1:0]   WdMax    = WdW'(TIMEOUT - 1);

    job_state_e       state_q, state_d;
    logic [15:0]      map_q, map_d;
    logic [2:0]       chip_q, chip_d;
    logic [8:0]       base_q, base_d;
    logic [3:0]       engine_q, engine_d;
    logic [WordW-1:0] word_q, word_d;
    logic [31:0]      hold_q, hold_d;
    logic [8:0]       mem_addr_q, mem_addr_d;
    logic [4:0]       issued_q, issued_d;
    logic             err_q, err_d;
    logic [WdW-1:0]   wdog_q, wdog_d;
    logic [31:0]      spi_tx_q, spi_tx_d;

    logic [7:0]       word_addr;
    logic [7:0]       frame_addr;
    logic [15:0]      frame_data;
    logic [31:0]      frame;
    logic             wdog_expired;

    assign word_addr    = REG_BASE + (8'(word_q) << 1);
    assign wdog_expired = (wdog_q == WdMax);

    // Next-state, datapath updates and watchdog.
    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        chip_d     = chip_q;
        base_d     = base_q;
        engine_d   = engine_q;
        word_d     = word_q;
        hold_d     = hold_q;
        mem_addr_d = mem_addr_q;
        issued_d   = issued_q;
        err_d      = err_q;
        wdog_d     = wdog_q;

        if (is_send_state(state_q)) begin
            wdog_d = '0;
        end else if (is_wait_state(state_q)) begin
            wdog_d = wdog_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (ModuleStart) state_d = StInit;
            end
            StInit: begin
                map_d    = EngineMap;
                chip_d   = ActualChipIndex;
                base_d   = Memory_Address_To_Start_Reading;
                engine_d = '0;
                word_d   = '0;
                issued_d = '0;
                err_d    = 1'b0;
                state_d  = StSelect;
            end
            StSelect: begin
                if (map_q == '0) begin
                    state_d = StDone;
                end else if (!map_q[engine_q]) begin
                    engine_d = engine_q + 4'd1;
                end else begin
                    word_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                mem_addr_d = base_q + 9'(word_q);
                state_d    = StFetchWait;
            end
            StFetchWait: state_d = StLoad;
            StLoad: begin
                hold_d  = Memory_ReadData;
                state_d = StSendLo;
            end
            StSendLo:   state_d = StWaitLo;
            StSendHi:   state_d = StWaitHi;
            StSendNlo:  state_d = StWaitNlo;
            StSendNhi:  state_d = StWaitNhi;
            StSendCtrl: state_d = StWaitCtrl;
            StWaitLo, StWaitHi, StWaitNlo, StWaitNhi, StWaitCtrl: begin
                // A DONE in the final watchdog cycle still counts as success.
                if (SPI_DONE) begin
                    unique case (state_q)
                        StWaitLo:  state_d = StSendHi;
                        StWaitHi: begin
                            if (word_q == LastWord) begin
                                state_d = StSendNlo;
                            end else begin
                                word_d  = word_q + 1'b1;
                                state_d = StFetch;
                            end
                        end
                        StWaitNlo: state_d = StSendNhi;
                        StWaitNhi: state_d = StSendCtrl;
                        default: begin
                            issued_d         = issued_q + 5'd1;
                            map_d[engine_q]  = 1'b0;
                            state_d          = StSelect;
                        end
                    endcase
                end else if (wdog_expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Select the frame for the SEND state about to be entered so SPI_TX is already
    // registered when SPI_START rises.
    always_comb begin
        frame_addr = '0;
        frame_data = '0;
        spi_tx_d   = spi_tx_q;
        case (state_d)
            StSendLo: begin
                frame_addr = word_addr;
                frame_data = hold_d[15:0];
            end
            StSendHi: begin
                frame_addr = word_addr + 8'd1;
                frame_data = hold_q[31:16];
            end
            StSendNlo: begin
                frame_addr = REG_NONCE_LO;
                frame_data = 16'h0000;
            end
            StSendNhi: begin
                frame_addr = REG_NONCE_HI;
                frame_data = {engine_q, 12'h000};
            end
            StSendCtrl: begin
                frame_addr = REG_CTRL;
                frame_data = CTRL_START;
            end
            default: ;
        endcase
        if (is_send_state(state_d)) spi_tx_d = frame;
    end

    spi_frame_builder u_frame (
        .rw_i     (SPI_RW_WRITE),
        .chip_i   (chip_q),
        .engine_i (engine_q),
        .addr_i   (frame_addr),
        .data_i   (frame_data),
        .frame_o  (frame)
    );

    // State and datapath registers.
    always_ff @(posedge SysClock or negedge SysReset_n) begin
        if (!SysReset_n) begin
            state_q    <= StIdle;
            map_q      <= '0;
            chip_q     <= '0;
            base_q     <= '0;
            engine_q   <= '0;
            word_q     <= '0;
            hold_q     <= '0;
            mem_addr_q <= '0;
            issued_q   <= '0;
            err_q      <= 1'b0;
            wdog_q     <= '0;
            spi_tx_q   <= '0;
        end else begin
            state_q    <= state_d;
            map_q      <= map_d;
            chip_q     <= chip_d;
            base_q     <= base_d;
            engine_q   <= engine_d;
            word_q     <= word_d;
            hold_q     <= hold_d;
            mem_addr_q <= mem_addr_d;
            issued_q   <= issued_d;
            err_q      <= err_d;
            wdog_q     <= wdog_d;
            spi_tx_q   <= spi_tx_d;
        end
    end

    assign SPI_TX         = spi_tx_q;
    assign SPI_START      = is_send_state(state_q);
    assign Memory_Address = mem_addr_q;
    assign EnginesIssued  = issued_q;
    assign Busy           = (state_q != StIdle);
    assign ModuleDone     = (state_q == StDone);
    assign ModuleError    = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_uengine_job_issuing.sv
// Directed bench for the job-issuing microengine with a RAM model and an SPI responder.
module tb_uengine_job_issuing;

    localparam int unsigned JobWords  = 11;
    localparam int          DoneDelay = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        module_start = 1'b0;
    logic        mstart_inj = 1'b0;
    logic        mstart;
    logic        module_done, module_error, busy;
    logic [15:0] engine_map = '0;
    logic [2:0]  chip = '0;
    logic [31:0] spi_tx;
    logic        spi_start;
    logic        spi_done = 1'b0;
    logic [8:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [8:0]  mem_base = '0;
    logic [4:0]  issued;

    logic [31:0] ram [512];
    logic [31:0] frames [$];
    logic [31:0] exp_q [$];

    int n_pass = 0, n_total = 0;
    int cyc = 0;
    int pending = 0;
    int start_cyc = 0;
    int tx_unstable = 0;
    int done_cnt = 0, err_cnt = 0, err_alone = 0;
    logic        stall_en = 1'b0;
    logic [3:0]  stall_eng = '0;
    logic        inject = 1'b0;
    logic [31:0] cur_tx = '0;

    assign mstart = module_start | mstart_inj;

    uengine_job_issuing dut (
        .SysClock                        (clk),
        .SysReset_n                      (rst_n),
        .ModuleStart                     (mstart),
        .ModuleDone                      (module_done),
        .ModuleError                     (module_error),
        .Busy                            (busy),
        .EngineMap                       (engine_map),
        .ActualChipIndex                 (chip),
        .SPI_TX                          (spi_tx),
        .SPI_START                       (spi_start),
        .SPI_DONE                        (spi_done),
        .Memory_Address                  (mem_addr),
        .Memory_ReadData                 (mem_rdata),
        .Memory_Address_To_Start_Reading (mem_base),
        .EnginesIssued                   (issued)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_rdata <= ram[mem_addr];

    // SPI master model: logs each frame, answers DONE after DoneDelay cycles.
    initial begin
        forever begin
            @(negedge clk);
            spi_done   = 1'b0;
            mstart_inj = 1'b0;
            if (!rst_n) begin
                pending = 0;
            end else if (spi_start) begin
                frames.push_back(spi_tx);
                cur_tx    = spi_tx;
                start_cyc = cyc;
                pending   = (stall_en && spi_tx[27:24] == stall_eng) ? -1 : DoneDelay;
                if (inject) begin
                    spi_done   = 1'b1;
                    mstart_inj = 1'b1;
                end
            end else if (pending > 0) begin
                if (spi_tx !== cur_tx) tx_unstable++;
                pending--;
                if (pending == 0) spi_done = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (module_done === 1'b1) done_cnt++;
            if (module_error === 1'b1) begin
                err_cnt++;
                if (module_done !== 1'b1) err_alone++;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic build_exp(input logic [15:0] map, input logic [2:0] ch, input logic [8:0] base);
        exp_q.delete();
        for (int e = 0; e < 16; e++) begin
            if (map[e]) begin
                for (int w = 0; w < int'(JobWords); w++) begin
                    logic [31:0] d;
                    logic [7:0]  a;
                    d = ram[base + 9'(w)];
                    a = 8'(8'h01 + 2 * w);
                    exp_q.push_back({1'b0, ch, 4'(e), a, d[15:0]});
                    exp_q.push_back({1'b0, ch, 4'(e), 8'(a + 8'd1), d[31:16]});
                end
                exp_q.push_back({1'b0, ch, 4'(e), 8'h20, 16'h0000});
                exp_q.push_back({1'b0, ch, 4'(e), 8'h21, 4'(e), 12'h000});
                exp_q.push_back({1'b0, ch, 4'(e), 8'h00, 16'h0001});
            end
        end
    endtask

    task automatic start_run(input logic [15:0] map, input logic [2:0] ch, input logic [8:0] base);
        @(negedge clk);
        engine_map   = map;
        chip         = ch;
        mem_base     = base;
        module_start = 1'b1;
        @(negedge clk);
        module_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int done_at, output bit ok);
        ok      = 1'b0;
        done_at = -1;
        for (int i = 0; i < budget; i++) begin
            if (module_done === 1'b1) begin
                ok      = 1'b1;
                done_at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++; if ({busy, module_done, module_error, spi_start} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want 0000", {busy, module_done, module_error, spi_start});
        else n_pass++;
        n_total++; if (spi_tx !== 32'h0) $display("FAIL reset_tx: got %h want 0", spi_tx);
        else n_pass++;
        n_total++; if (mem_addr !== 9'h0 || issued !== 5'h0)
            $display("FAIL reset_addr_issued: got %h/%h want 0/0", mem_addr, issued);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_engine();
        int t, d0, u0; bit ok;
        frames.delete(); d0 = done_cnt; u0 = tx_unstable;
        build_exp(16'h0001, 3'd0, 9'd0);
        start_run(16'h0001, 3'd0, 9'd0);
        wait_done(5000, t, ok);
        repeat (3) @(negedge clk);
        n_total++; if (!ok) $display("FAIL single_done: got timeout want ModuleDone"); else n_pass++;
        n_total++; if (frames.size() != 25) $display("FAIL single_count: got %0d want 25", frames.size());
        else n_pass++;
        n_total++; if (frames[0] !== 32'h0001_0000) $display("FAIL single_first: got %h want 00010000", frames[0]);
        else n_pass++;
        n_total++; if (frames[1] !== 32'h0002_A000) $display("FAIL single_second: got %h want 0002a000", frames[1]);
        else n_pass++;
        n_total++; if (frames[22] !== 32'h0020_0000) $display("FAIL single_nlo: got %h want 00200000", frames[22]);
        else n_pass++;
        n_total++; if (frames[23] !== 32'h0021_0000) $display("FAIL single_nhi: got %h want 00210000", frames[23]);
        else n_pass++;
        n_total++; if (frames[24] !== 32'h0000_0001) $display("FAIL single_ctrl: got %h want 00000001", frames[24]);
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
            n_total++; if (frames[i] !== exp_q[i])
                $display("FAIL single_frame[%0d]: got %h want %h", i, frames[i], exp_q[i]);
            else n_pass++;
        end
        n_total++; if (issued !== 5'd1) $display("FAIL single_issued: got %0d want 1", issued); else n_pass++;
        n_total++; if (done_cnt - d0 != 1) $display("FAIL single_done_cnt: got %0d want 1", done_cnt - d0);
        else n_pass++;
        n_total++; if (tx_unstable != u0) $display("FAIL single_tx_stable: got %0d want 0", tx_unstable - u0);
        else n_pass++;
    endtask

    task automatic test_two_engines();
        int t; bit ok; logic [31:0] f;
        frames.delete();
        build_exp(16'h8001, 3'd5, 9'd0);
        start_run(16'h8001, 3'd5, 9'd0);
        wait_done(5000, t, ok);
        repeat (3) @(negedge clk);
        n_total++; if (!ok) $display("FAIL two_done: got timeout want ModuleDone"); else n_pass++;
        n_total++; if (frames.size() != 50) $display("FAIL two_count: got %0d want 50", frames.size());
        else n_pass++;
        f = frames[25];
        n_total++; if (f[30:24] !== 7'h5F) $display("FAIL two_e15_hdr: got %h want 5f", f[30:24]);
        else n_pass++;
        n_total++; if (frames[48] !== 32'h5F21_F000) $display("FAIL two_e15_nhi: got %h want 5f21f000", frames[48]);
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
            n_total++; if (frames[i] !== exp_q[i])
                $display("FAIL two_frame[%0d]: got %h want %h", i, frames[i], exp_q[i]);
            else n_pass++;
        end
        n_total++; if (issued !== 5'd2) $display("FAIL two_issued: got %0d want 2", issued); else n_pass++;
    endtask

    task automatic test_empty_map();
        int n; int d0;
        frames.delete(); d0 = done_cnt; n = -1;
        @(negedge clk);
        engine_map   = 16'h0000;
        module_start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) module_start = 1'b0;
            if (module_done === 1'b1) begin
                n = i;
                break;
            end
        end
        repeat (3) @(negedge clk);
        n_total++; if (n != 3) $display("FAIL empty_latency: got %0d want 3", n); else n_pass++;
        n_total++; if (frames.size() != 0) $display("FAIL empty_frames: got %0d want 0", frames.size());
        else n_pass++;
        n_total++; if (issued !== 5'd0) $display("FAIL empty_issued: got %0d want 0", issued); else n_pass++;
        n_total++; if (done_cnt - d0 != 1) $display("FAIL empty_done_cnt: got %0d want 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int t, e0, a0; bit ok; logic [31:0] d;
        frames.delete(); e0 = err_cnt; a0 = err_alone;
        stall_en  = 1'b1;
        stall_eng = 4'd2;
        start_run(16'h0007, 3'd1, 9'h100);
        wait_done(5000, t, ok);
        repeat (3) @(negedge clk);
        stall_en = 1'b0;
        d = ram[9'h100];
        n_total++; if (!ok) $display("FAIL timeout_done: got no ModuleDone want abort"); else n_pass++;
        n_total++; if (t - start_cyc != 1025)
            $display("FAIL timeout_latency: got %0d want 1025", t - start_cyc);
        else n_pass++;
        n_total++; if (err_cnt - e0 != 1 || err_alone != a0)
            $display("FAIL timeout_error: got %0d errors (%0d alone) want 1 (0)", err_cnt - e0, err_alone - a0);
        else n_pass++;
        n_total++; if (issued !== 5'd2) $display("FAIL timeout_issued: got %0d want 2", issued); else n_pass++;
        n_total++; if (frames.size() != 51) $display("FAIL timeout_count: got %0d want 51", frames.size());
        else n_pass++;
        n_total++; if (frames[50] !== {4'b0001, 4'd2, 8'h01, d[15:0]})
            $display("FAIL timeout_stalled_frame: got %h want %h", frames[50], {4'b0001, 4'd2, 8'h01, d[15:0]});
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int t; bit ok;
        frames.delete();
        start_run(16'h0003, 3'd0, 9'd0);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frames.size() >= 27) begin
                ok = 1'b1;
                break;
            end
        end
        n_total++; if (!ok) $display("FAIL rstmid_reach: got %0d frames want 27", frames.size()); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if ({busy, spi_start, module_done} !== 3'b000)
            $display("FAIL rstmid_ctrl: got %b want 000", {busy, spi_start, module_done});
        else n_pass++;
        n_total++; if (spi_tx !== 32'h0 || mem_addr !== 9'h0 || issued !== 5'h0)
            $display("FAIL rstmid_regs: got %h/%h/%h want 0/0/0", spi_tx, mem_addr, issued);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frames.delete();
        build_exp(16'h0003, 3'd0, 9'd0);
        start_run(16'h0003, 3'd0, 9'd0);
        wait_done(5000, t, ok);
        repeat (3) @(negedge clk);
        n_total++; if (!ok) $display("FAIL rstmid_done: got timeout want ModuleDone"); else n_pass++;
        n_total++; if (frames.size() != 50) $display("FAIL rstmid_count: got %0d want 50", frames.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
            n_total++; if (frames[i] !== exp_q[i])
                $display("FAIL rstmid_frame[%0d]: got %h want %h", i, frames[i], exp_q[i]);
            else n_pass++;
        end
        n_total++; if (issued !== 5'd2) $display("FAIL rstmid_issued: got %0d want 2", issued); else n_pass++;
    endtask

    task automatic test_noise();
        int t, d0, e0; bit ok;
        frames.delete(); d0 = done_cnt; e0 = err_cnt;
        build_exp(16'h0011, 3'd3, 9'h100);
        inject = 1'b1;
        start_run(16'h0011, 3'd3, 9'h100);
        wait_done(5000, t, ok);
        inject = 1'b0;
        repeat (20) @(negedge clk);
        n_total++; if (!ok) $display("FAIL noise_done: got timeout want ModuleDone"); else n_pass++;
        n_total++; if (frames.size() != 50) $display("FAIL noise_count: got %0d want 50", frames.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
            n_total++; if (frames[i] !== exp_q[i])
                $display("FAIL noise_frame[%0d]: got %h want %h", i, frames[i], exp_q[i]);
            else n_pass++;
        end
        n_total++; if (issued !== 5'd2) $display("FAIL noise_issued: got %0d want 2", issued); else n_pass++;
        n_total++; if (done_cnt - d0 != 1 || err_cnt != e0)
            $display("FAIL noise_done_cnt: got %0d dones %0d errors want 1 0", done_cnt - d0, err_cnt - e0);
        else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL noise_idle: got busy=%b want 0", busy); else n_pass++;
    endtask

    initial begin
        for (int j = 0; j < 512; j++) begin
            ram[j] = (j < 256) ? 32'hA000_0000 + 32'(j) : 32'hC3C3_0000 ^ (32'(j) * 32'h0003_0007);
        end
        test_reset();
        test_single_engine();
        test_two_engines();
        test_empty_map();
        test_timeout();
        test_reset_mid_run();
        test_noise();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
